// File: rtl/dot8_mac_pipe_if.sv
// Execute-request and result channels of the DOT8 processing element.
// The slave modport is the PE side; master is the issuing/consuming side.
interface dot8_mac_pipe_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TAG_WIDTH = 64
);
    logic                      exe_valid;
    logic                      exe_ready;
    logic [NUM_LANES*32-1:0]   exe_rs1;
    logic [NUM_LANES*32-1:0]   exe_rs2;
    logic [NUM_LANES*32-1:0]   exe_rs3;
    logic [TAG_WIDTH-1:0]      exe_tag;

    logic                      res_valid;
    logic                      res_ready;
    logic [NUM_LANES*32-1:0]   res_data;
    logic [TAG_WIDTH-1:0]      res_tag;

    modport master (
        output exe_valid, exe_rs1, exe_rs2, exe_rs3, exe_tag, res_ready,
        input  exe_ready, res_valid, res_data, res_tag
    );

    modport slave (
        input  exe_valid, exe_rs1, exe_rs2, exe_rs3, exe_tag, res_ready,
        output exe_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/dot8_mac_pipe.sv
// Pipelined signed int8 4-way dot product per lane with the issue tag delayed in lockstep.
// Define DOT8_ACC_EN to add exe_rs3 (modulo 2^32) into each lane result.
module dot8_mac_pipe #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned TAG_WIDTH = 64
) (
    input logic            clk,
    input logic            reset,
    dot8_mac_pipe_if.slave bus
);
    localparam int unsigned DW = NUM_LANES * 32;

    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("dot8_mac_pipe: LATENCY must be in 1..3");
    end

    function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        return sa * sb;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sext17(input logic [16:0] v);
        return {{15{v[16]}}, v};
    endfunction

    logic                 stall;
    logic [LATENCY-1:0]   valid_q;
    logic [TAG_WIDTH-1:0] tag_q [LATENCY];
    logic [DW-1:0]        res_q;
    logic [DW-1:0]        acc_in;
    logic [15:0]          prod [NUM_LANES][4];

`ifdef DOT8_ACC_EN
    assign acc_in = bus.exe_rs3;
`else
    logic unused_rs3;
    assign acc_in     = '0;
    assign unused_rs3 = ^bus.exe_rs3;
`endif

    // Bubbles are not collapsed: the whole pipe freezes on a blocked output.
    assign stall         = valid_q[LATENCY-1] & ~bus.res_ready;
    assign bus.exe_ready = ~stall;
    assign bus.res_valid = valid_q[LATENCY-1];
    assign bus.res_data  = res_q;
    assign bus.res_tag   = tag_q[LATENCY-1];

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int k = 0; k < 4; k++) begin
                prod[l][k] = mul8(bus.exe_rs1[32*l+8*k +: 8], bus.exe_rs2[32*l+8*k +: 8]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (!stall) begin
            valid_q[0] <= bus.exe_valid;
            tag_q[0]   <= bus.exe_tag;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    if (LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                res_q <= '0;
            end else if (!stall) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    res_q[32*l +: 32] <= acc_in[32*l +: 32]
                                       + sext16(prod[l][0]) + sext16(prod[l][1])
                                       + sext16(prod[l][2]) + sext16(prod[l][3]);
                end
            end
        end
    end else if (LATENCY == 2) begin : g_lat2
        logic [15:0]   prod_q [NUM_LANES][4];
        logic [DW-1:0] acc_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    for (int k = 0; k < 4; k++) begin
                        prod_q[l][k] <= '0;
                    end
                end
                acc_q <= '0;
                res_q <= '0;
            end else if (!stall) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    for (int k = 0; k < 4; k++) begin
                        prod_q[l][k] <= prod[l][k];
                    end
                    res_q[32*l +: 32] <= acc_q[32*l +: 32]
                                       + sext16(prod_q[l][0]) + sext16(prod_q[l][1])
                                       + sext16(prod_q[l][2]) + sext16(prod_q[l][3]);
                end
                acc_q <= acc_in;
            end
        end
    end else if (LATENCY == 3) begin : g_lat3
        logic [15:0]   prod_q [NUM_LANES][4];
        logic [16:0]   pair_q [NUM_LANES][2];
        logic [DW-1:0] acc1_q;
        logic [DW-1:0] acc2_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    for (int k = 0; k < 4; k++) begin
                        prod_q[l][k] <= '0;
                    end
                    pair_q[l][0] <= '0;
                    pair_q[l][1] <= '0;
                end
                acc1_q <= '0;
                acc2_q <= '0;
                res_q  <= '0;
            end else if (!stall) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    for (int k = 0; k < 4; k++) begin
                        prod_q[l][k] <= prod[l][k];
                    end
                    pair_q[l][0] <= {prod_q[l][0][15], prod_q[l][0]}
                                  + {prod_q[l][1][15], prod_q[l][1]};
                    pair_q[l][1] <= {prod_q[l][2][15], prod_q[l][2]}
                                  + {prod_q[l][3][15], prod_q[l][3]};
                    res_q[32*l +: 32] <= acc2_q[32*l +: 32]
                                       + sext17(pair_q[l][0]) + sext17(pair_q[l][1]);
                end
                acc1_q <= acc_in;
                acc2_q <= acc1_q;
            end
        end
    end
endmodule

// File: tb/tb_dot8_mac_pipe.sv
// Directed self-checking bench for dot8_mac_pipe; instances at LATENCY 1, 2 and 3 share stimulus.
`timescale 1ns/1ps
module tb_dot8_mac_pipe;
    localparam int unsigned NL = 4;
    localparam int unsigned TW = 64;
    localparam int unsigned DW = NL * 32;
`ifdef DOT8_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          exe_valid;
    logic          res_ready;
    logic [DW-1:0] rs1, rs2, rs3;
    logic [TW-1:0] tag;

    logic [2:0]    v, rdy;
    logic [DW-1:0] d [3];
    logic [TW-1:0] t [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dot8_mac_pipe_if #(.NUM_LANES(NL), .TAG_WIDTH(TW)) bus ();
        assign bus.exe_valid = exe_valid;
        assign bus.exe_rs1   = rs1;
        assign bus.exe_rs2   = rs2;
        assign bus.exe_rs3   = rs3;
        assign bus.exe_tag   = tag;
        assign bus.res_ready = res_ready;
        assign v[g]   = bus.res_valid;
        assign rdy[g] = bus.exe_ready;
        assign d[g]   = bus.res_data;
        assign t[g]   = bus.res_tag;
        dot8_mac_pipe #(.NUM_LANES(NL), .LATENCY(g + 1), .TAG_WIDTH(TW)) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );
    end

    function automatic logic [DW-1:0] ref_dot(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] c);
        logic [DW-1:0] r;
        int s;
        for (int l = 0; l < NL; l++) begin
            s = ACC_EN ? int'(c[32*l +: 32]) : 0;
            for (int k = 0; k < 4; k++) begin
                s += int'($signed(a[32*l+8*k +: 8])) * int'($signed(b[32*l+8*k +: 8]));
            end
            r[32*l +: 32] = s;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; exe_valid = 1'b0; res_ready = 1'b1;
        rs1 = '0; rs2 = '0; rs3 = '0; tag = '0;
        repeat (2) tick();
        #2 reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (v[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid L%0d: got %b want 0", i + 1, v[i]); end
            n_checks++; if (d[i] !== '0) begin n_fail++; $display("FAIL reset_data L%0d: got %h want 0", i + 1, d[i]); end
            n_checks++; if (t[i] !== '0) begin n_fail++; $display("FAIL reset_tag L%0d: got %h want 0", i + 1, t[i]); end
            n_checks++; if (rdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready L%0d: got %b want 1", i + 1, rdy[i]); end
        end
        // res_ready toggling on an empty pipe must not matter
        res_ready = 1'b0;
        #1;
        n_checks++; if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", rdy[1]); end
        tick();
        res_ready = 1'b1;
        n_checks++; if (v[1] !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", v[1]); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d;
        logic [TW-1:0] exp_t;
        exp_d = {32'h0000_0000, 32'h0000_FC04, 32'hFFFF_FFF8, 32'h0000_000A};
        exp_t = 64'hDEAD_BEEF_0123_4567;
        rs1 = {32'h0000_0000, 32'h7F7F_7F7F, 32'hFFFF_FFFF, 32'h0403_0201};
        rs2 = {32'h0000_0000, 32'h7F7F_7F7F, 32'h0202_0202, 32'h0101_0101};
        rs3 = '0; tag = exp_t; exe_valid = 1'b1;
        tick();
        exe_valid = 1'b0; rs1 = '0; rs2 = '0; tag = '0;
        n_checks++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL basic_l1_valid: got %b want 1", v[0]); end
        n_checks++; if (d[0] !== exp_d) begin n_fail++; $display("FAIL basic_l1_data: got %h want %h", d[0], exp_d); end
        n_checks++; if (v[1] !== 1'b0) begin n_fail++; $display("FAIL basic_l2_early: got %b want 0", v[1]); end
        tick();
        n_checks++; if (v[1] !== 1'b1) begin n_fail++; $display("FAIL basic_l2_valid: got %b want 1", v[1]); end
        n_checks++; if (d[1] !== exp_d) begin n_fail++; $display("FAIL basic_l2_data: got %h want %h", d[1], exp_d); end
        n_checks++; if (t[1] !== exp_t) begin n_fail++; $display("FAIL basic_l2_tag: got %h want %h", t[1], exp_t); end
        n_checks++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL basic_l1_drain: got %b want 0", v[0]); end
        n_checks++; if (v[2] !== 1'b0) begin n_fail++; $display("FAIL basic_l3_early: got %b want 0", v[2]); end
        tick();
        n_checks++; if (v[2] !== 1'b1) begin n_fail++; $display("FAIL basic_l3_valid: got %b want 1", v[2]); end
        n_checks++; if (d[2] !== exp_d) begin n_fail++; $display("FAIL basic_l3_data: got %h want %h", d[2], exp_d); end
        n_checks++; if (v[1] !== 1'b0) begin n_fail++; $display("FAIL basic_l2_drain: got %b want 0", v[1]); end
        tick();
    endtask

    task automatic test_extremes();
        logic [DW-1:0] exp_d;
        exp_d = {32'h0000_0000, 32'h0000_0201, 32'hFFFF_0200, 32'h0001_0000};
        rs1 = {32'h0000_0000, 32'h7F80_FF01, 32'h8080_8080, 32'h8080_8080};
        rs2 = {32'h1234_5678, 32'h02FF_8003, 32'h7F7F_7F7F, 32'h8080_8080};
        rs3 = '0; tag = 64'h1; exe_valid = 1'b1;
        tick();
        exe_valid = 1'b0;
        tick();
        n_checks++; if (v[1] !== 1'b1) begin n_fail++; $display("FAIL extreme_valid: got %b want 1", v[1]); end
        n_checks++; if (d[1] !== exp_d) begin n_fail++; $display("FAIL extreme_data: got %h want %h", d[1], exp_d); end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q1 [5], q2 [5], q3 [5], exp_d [5];
        logic [TW-1:0] qt [5];
        logic [DW-1:0] held_d;
        logic [TW-1:0] held_t;
        logic stall_prev;
        int sent, got;
        sent = 0; got = 0; stall_prev = 1'b0; held_d = '0; held_t = '0;
        for (int i = 0; i < 5; i++) begin
            q1[i] = {$urandom, $urandom, $urandom, $urandom};
            q2[i] = {$urandom, $urandom, $urandom, $urandom};
            q3[i] = {$urandom, $urandom, $urandom, $urandom};
            qt[i] = {32'hB0B0_0000, 32'(i)};
            exp_d[i] = ref_dot(q1[i], q2[i], q3[i]);
        end
        for (int c = 0; c < 30; c++) begin
            res_ready = !(c >= 3 && c <= 6);
            exe_valid = (sent < 5);
            if (sent < 5) begin rs1 = q1[sent]; rs2 = q2[sent]; rs3 = q3[sent]; tag = qt[sent]; end
            @(negedge clk);
            n_checks++; if (rdy[1] !== !(v[1] && !res_ready)) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want %b", c, rdy[1], !(v[1] && !res_ready)); end
            if (stall_prev && v[1]) begin
                n_checks++; if (d[1] !== held_d || t[1] !== held_t) begin n_fail++; $display("FAIL bp_hold c%0d: got %h/%h want %h/%h", c, d[1], t[1], held_d, held_t); end
            end
            if (v[1] && res_ready) begin
                n_checks++;
                if (got >= 5) begin n_fail++; $display("FAIL bp_dup c%0d: got extra result %h want none", c, d[1]); end
                else if (d[1] !== exp_d[got] || t[1] !== qt[got]) begin
                    n_fail++; $display("FAIL bp_order #%0d: got %h/%h want %h/%h", got, d[1], t[1], exp_d[got], qt[got]);
                end
                got++;
            end
            stall_prev = v[1] && !res_ready;
            held_d = d[1]; held_t = t[1];
            if (exe_valid && rdy[1]) sent++;
            tick();
        end
        exe_valid = 1'b0; res_ready = 1'b1;
        n_checks++; if (got !== 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", got); end
    endtask

    task automatic test_reset_midflight();
        res_ready = 1'b1; rs3 = '0;
        rs1 = {4{32'h0101_0101}}; rs2 = {4{32'h0101_0101}}; tag = 64'hA; exe_valid = 1'b1;
        tick();
        rs1 = {4{32'h0202_0202}}; tag = 64'hB;
        tick();
        exe_valid = 1'b0;
        n_checks++; if (v[1] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", v[1]); end
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (v[i] !== 1'b0) begin n_fail++; $display("FAIL mid_valid L%0d: got %b want 0", i + 1, v[i]); end
            n_checks++; if (d[i] !== '0) begin n_fail++; $display("FAIL mid_data L%0d: got %h want 0", i + 1, d[i]); end
        end
        repeat (2) tick();
        #2 reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (v !== 3'b000) begin n_fail++; $display("FAIL mid_after c%0d: got %b want 000", c, v); end
        end
        n_checks++; if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", rdy[1]); end
    endtask

    task automatic test_latency_sweep();
        logic [DW-1:0] exp_d [20];
        logic [TW-1:0] exp_t [20];
        logic [DW-1:0] a, b, c3;
        int idx;
        logic exp_v;
        res_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            exe_valid = (c < 20);
            if (c < 20) begin
                a = {$urandom, $urandom, $urandom, $urandom};
                b = {$urandom, $urandom, $urandom, $urandom};
                c3 = {$urandom, $urandom, $urandom, $urandom};
                rs1 = a; rs2 = b; rs3 = c3; tag = {$urandom, $urandom};
                exp_d[c] = ref_dot(a, b, c3); exp_t[c] = tag;
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                idx = c - i;
                exp_v = (idx >= 0 && idx < 20);
                n_checks++; if (v[i] !== exp_v) begin n_fail++; $display("FAIL sweep_valid L%0d c%0d: got %b want %b", i + 1, c, v[i], exp_v); end
                if (exp_v) begin
                    n_checks++; if (d[i] !== exp_d[idx] || t[i] !== exp_t[idx]) begin
                        n_fail++; $display("FAIL sweep_data L%0d #%0d: got %h/%h want %h/%h", i + 1, idx, d[i], t[i], exp_d[idx], exp_t[idx]);
                    end
                end
            end
        end
        exe_valid = 1'b0;
    endtask

    task automatic test_acc();
        logic [DW-1:0] exp_d;
        exp_d = ACC_EN ? {{3{32'h0000_0028}}, 32'h0000_0000} : {{3{32'h0000_0018}}, 32'h0000_0001};
        rs1 = {{3{32'h0202_0202}}, 32'h0000_0001};
        rs2 = {{3{32'h0303_0303}}, 32'h0000_0001};
        rs3 = {{3{32'h0000_0010}}, 32'hFFFF_FFFF};
        tag = 64'h5; exe_valid = 1'b1; res_ready = 1'b1;
        tick();
        exe_valid = 1'b0;
        tick();
        n_checks++; if (v[1] !== 1'b1) begin n_fail++; $display("FAIL acc_valid: got %b want 1", v[1]); end
        n_checks++; if (d[1] !== exp_d) begin n_fail++; $display("FAIL acc_data: got %h want %h", d[1], exp_d); end
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_reset_midflight();
        test_latency_sweep();
        test_acc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
